// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory, buffers
// fetched words in a 2-entry FIFO for decode, and provides an idle-time loader.
module instruction_fetch_unit #(
  parameter int unsigned         ADDR_W    = 64,
  parameter int unsigned         DATA_W    = 64,
  parameter int unsigned         MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter int unsigned         PC_STEP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              mem_enable,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_fault;
  logic              r_hpend;
  logic              r_fl;
  logic [ADDR_W-1:0] r_fl_pc;
  logic [ADDR_W-1:0] r_q_pc   [2];
  logic [DATA_W-1:0] r_q_data [2];
  logic              r_rd;
  logic              r_wr;
  logic [1:0]        r_cnt;

  logic              w_redir;
  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic              w_try;
  logic              w_oob;
  logic              w_issue;
  logic              w_load;
  logic              w_halt;

  assign w_redir = redirect_valid & (r_state != S_IDLE);
  assign w_pop   = (r_cnt != 2'd0) & inst_ready & ~w_redir;
  assign w_push  = r_fl & ~w_redir;
  // Occupancy counts the slot freed by this cycle's pop to sustain 1/cycle.
  assign w_occ   = 3'(r_cnt) + 3'(r_fl) - 3'(w_pop);
  assign w_try   = (r_state == S_RUN) & ~r_fault & ~w_redir
                 & (w_occ < 3'd2);
  assign w_oob   = r_pc >= DEPTH;
  assign w_issue = w_try & ~w_oob;
  assign w_load  = (r_state == S_IDLE) & load_valid & rst_n;
  assign w_halt  = halt | r_hpend;

  assign mem_enable  = w_issue | w_load;
  assign mem_read    = w_issue;
  assign mem_address = w_issue ? r_pc
                     : w_load  ? load_addr
                     : '0;
  assign mem_data_in = w_load ? load_data : '0;

  assign inst_valid = r_cnt != 2'd0;
  assign inst_data  = inst_valid ? r_q_data[r_rd] : '0;
  assign inst_pc    = inst_valid ? r_q_pc[r_rd] : '0;
  assign busy       = r_state != S_IDLE;
  assign fault      = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_fault     <= 1'b0;
      r_hpend     <= 1'b0;
      r_fl        <= 1'b0;
      r_fl_pc     <= '0;
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_cnt       <= 2'd0;
    end else begin
      r_hpend <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_halt) begin
            if (w_redir) r_hpend <= 1'b1;
            else         r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_fl && r_cnt == 2'd0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_redir) begin
        r_pc    <= redirect_pc;
        r_fault <= 1'b0;
      end else if (w_try && w_oob) begin
        r_fault <= 1'b1;
      end else if (w_issue) begin
        r_pc <= r_pc + STEP;
      end

      r_fl <= w_issue;
      if (w_issue) r_fl_pc <= r_pc;

      if (w_redir) begin
        r_cnt <= 2'd0;
        r_rd  <= 1'b0;
        r_wr  <= 1'b0;
      end else begin
        if (w_push) begin
          r_q_pc[r_wr]   <= r_fl_pc;
          r_q_data[r_wr] <= mem_data_out;
          r_wr           <= ~r_wr;
        end
        if (w_pop) r_rd <= ~r_rd;
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory device, in-order delivery model,
// and directed scenarios for load, backpressure, redirect, fault, halt, reset.
module tb_instruction_fetch_unit;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        halt;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        load_valid;
  logic [63:0] load_addr;
  logic [63:0] load_data;
  logic        mem_enable;
  logic        mem_read;
  logic [63:0] mem_address;
  logic [63:0] mem_data_in;
  logic [63:0] mem_data_out;
  logic        inst_valid;
  logic        inst_ready;
  logic [63:0] inst_data;
  logic [63:0] inst_pc;
  logic        busy;
  logic        fault;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .mem_enable(mem_enable),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [63:0] mem  [DEPTH];
  logic [63:0] gold [DEPTH];

  int checks   = 0;
  int failures = 0;
  int n_reads  = 0;
  int n_pops   = 0;

  logic [63:0] m_next_pc = 64'd0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_pc;
  logic [63:0] prev_data;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory device with one-cycle registered read.
  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_read)
        mem_data_out <= (mem_address < DEPTH) ? mem[mem_address[9:0]] : 64'd0;
      else if (mem_address < DEPTH)
        mem[mem_address[9:0]] <= mem_data_in;
    end
  end

  // Delivery model: decode must see consecutive PCs from the last
  // start/redirect target, each carrying the word the loader put there.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_next_pc = 64'd0;
      prev_hold = 1'b0;
    end else begin
      if (mem_enable && mem_read) begin
        n_reads++;
        chk("read_in_range", 64'(mem_address < DEPTH), 64'd1);
      end
      if (!mem_enable)
        chk("idle_bus", {mem_read, mem_address, mem_data_in}, '0);
      if (prev_hold) begin
        chk("hold_valid", 64'(inst_valid), 64'd1);
        chk("hold_pc", inst_pc, prev_pc);
        chk("hold_data", inst_data, prev_data);
      end
      if (redirect_valid && busy) begin
        m_next_pc = redirect_pc;
      end else if (inst_valid && inst_ready) begin
        chk("pop_pc", inst_pc, m_next_pc);
        chk("pop_in_range", 64'(m_next_pc < DEPTH), 64'd1);
        chk("pop_data", inst_data,
            (m_next_pc < DEPTH) ? gold[m_next_pc[9:0]] : 64'd0);
        m_next_pc = m_next_pc + 64'd1;
        n_pops++;
      end
      prev_hold = inst_valid && !inst_ready && !(redirect_valid && busy);
      prev_pc   = inst_pc;
      prev_data = inst_data;
    end
  end

  task automatic load(input logic [63:0] a, input logic [63:0] d);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    #1;
    chk("ld_en", 64'(mem_enable), 64'd1);
    chk("ld_rd", 64'(mem_read), 64'd0);
    chk("ld_addr", mem_address, a);
    chk("ld_data", mem_data_in, d);
    gold[a[9:0]] = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!inst_valid && n < 10) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    int np0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = 64'd0;
      gold[i] = 64'd0;
    end
    mem_data_out   = 64'd0;
    rst_n          = 1'b0;
    start          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    load_valid     = 1'b0;
    load_addr      = 64'd0;
    load_data      = 64'd0;
    inst_ready     = 1'b0;
    tick(); tick(); tick();
    chk("rst_mem_en", 64'(mem_enable), 64'd0);
    chk("rst_mem_bus", {mem_read, mem_address, mem_data_in}, '0);
    chk("rst_inst", {inst_valid, inst_data, inst_pc}, '0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 32; i++)
      load(64'(i), (i < 4) ? 64'hA0 + 64'(i) : 64'h100 + 64'(i));
    load(64'h10, 64'hBB);
    load(64'd1023, 64'hEE);

    // Load then fetch with decode always ready.
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_busy", 64'(busy), 64'd1);
    wait_valid(n);
    chk("a_first_lat", 64'(n), 64'd2);
    chk("a_pc0", inst_pc, 64'd0);
    chk("a_data0", inst_data, 64'hA0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("a_valid", 64'(inst_valid), 64'd1);
      chk("a_pc", inst_pc, 64'(k));
      chk("a_data", inst_data, 64'hA0 + 64'(k));
    end

    // Asynchronous reset mid-cycle with reads in flight.
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mem", {63'd0, mem_enable}, 64'd0);
    chk("ar_bus", {mem_read, mem_address, mem_data_in}, '0);
    chk("ar_inst", {inst_valid, inst_data, inst_pc}, '0);
    chk("ar_busy", {62'd0, busy, fault}, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    r0 = n_reads;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ar_no_valid", 64'(inst_valid), 64'd0);
      chk("ar_idle", 64'(busy), 64'd0);
    end
    chk("ar_no_reads", 64'(n_reads - r0), 64'd0);

    // Backpressure from the first valid.
    inst_ready = 1'b0;
    r0 = n_reads;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(n);
    chk("b_first_lat", 64'(n), 64'd2);
    chk("b_pc0", inst_pc, 64'd0);
    chk("b_data0", inst_data, 64'hA0);
    np0 = n_reads;
    for (int k = 0; k < 5; k++) tick();
    chk("b_head_pc", inst_pc, 64'd0);
    chk("b_stall_reads", 64'(n_reads - np0), 64'd0);
    chk("b_total_reads", 64'(n_reads - r0), 64'd2);
    inst_ready = 1'b1;
    tick();
    chk("b_nogap_valid", 64'(inst_valid), 64'd1);
    chk("b_nogap_pc", inst_pc, 64'd1);
    chk("b_nogap_data", inst_data, 64'hA1);

    // Redirect while pc 2 is at the head.
    n = 0;
    while (!(inst_valid && inst_pc == 64'd2) && n < 6) begin
      tick();
      n++;
    end
    chk("r_reach_pc2", inst_pc, 64'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h10;
    tick();
    redirect_valid = 1'b0;
    chk("r_flushed", 64'(inst_valid), 64'd0);
    wait_valid(n);
    chk("r_lat", 64'(n), 64'd2);
    chk("r_pc", inst_pc, 64'h10);
    chk("r_data", inst_data, 64'hBB);

    // Fault at the last legal word.
    redirect_valid = 1'b1;
    redirect_pc    = 64'd1023;
    tick();
    redirect_valid = 1'b0;
    wait_valid(n);
    chk("f_pc", inst_pc, 64'd1023);
    chk("f_data", inst_data, 64'hEE);
    r0 = n_reads;
    for (int k = 0; k < 4; k++) tick();
    chk("f_fault", 64'(fault), 64'd1);
    chk("f_no_valid", 64'(inst_valid), 64'd0);
    chk("f_busy", 64'(busy), 64'd1);
    chk("f_no_reads", 64'(n_reads - r0), 64'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'd0;
    tick();
    redirect_valid = 1'b0;
    chk("f_cleared", 64'(fault), 64'd0);
    wait_valid(n);
    chk("f_resume_pc", inst_pc, 64'd0);
    chk("f_resume_data", inst_data, 64'hA0);

    // Halt with two buffered, loader ignored while draining.
    inst_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    np0 = n_pops;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h_busy", 64'(busy), 64'd1);
    load_valid = 1'b1;
    load_addr  = 64'd5;
    load_data  = 64'hDEAD;
    #1;
    chk("h_load_ignored", 64'(mem_enable), 64'd0);
    tick();
    load_valid = 1'b0;
    inst_ready = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      tick();
      n++;
    end
    chk("h_idle", 64'(busy), 64'd0);
    chk("h_drained", 64'(n_pops - np0), 64'd2);
    chk("h_empty", 64'(inst_valid), 64'd0);
    chk("h_mem5", mem[5], 64'h105);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction memory port: owns the program counter and drives enable/read/address/data_in to the instruction memory.
- Captures the 1-cycle-latency read data and hands instructions to decode over a valid/ready handshake.
- Supports branch redirect and flush.
- Provides a loader write path so a program can be written into memory while fetch is idle.

Parameters:
- ADDR_W, 64, width of PC and memory address
- DATA_W, 64, instruction/data width
- MEM_DEPTH, 1024, number of memory words; legal word addresses are 0..MEM_DEPTH-1
- RESET_PC, 0, PC value after reset
- PC_STEP, 1, PC increment per instruction (memory is word-addressed)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: leave IDLE and begin fetching at the current PC
- halt  in  1  pulse: stop issuing, drain, return to IDLE
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  new PC
- load_valid  in  1  loader write request (honoured only in IDLE)
- load_addr  in  ADDR_W  loader word address
- load_data  in  DATA_W  loader write data
- mem_enable  out  1  memory enable
- mem_read  out  1  1 = read, 0 = write
- mem_address  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  write data to memory
- mem_data_out  in  DATA_W  registered read data from memory
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts
- inst_data  out  DATA_W  instruction word
- inst_pc  out  ADDR_W  PC of inst_data
- busy  out  1  state != IDLE
- fault  out  1  sticky: PC reached an address >= MEM_DEPTH

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC.
  - Output FIFO empty, in-flight flag cleared, fault=0.
  - All mem_* outputs 0; inst_valid=0, inst_data=0, inst_pc=0, busy=0.
- Memory timing:
  - A read issued in cycle N (mem_enable=1, mem_read=1, mem_address=pc) returns data on mem_data_out after edge N.
  - The unit samples it in cycle N+1 and tags it with the issuing PC.
- Buffering:
  - 2-entry output FIFO of {pc, data}.
  - Issue a read only when fifo_count + inflight < 2, state=RUN, fault=0, no redirect this cycle.
  - Gives 1 instruction/cycle with inst_ready held high.
- Handshake:
  - inst_data/inst_pc are the FIFO head.
  - inst_valid = FIFO non-empty.
  - Pop on inst_valid & inst_ready.
  - Head is stable while inst_valid=1 and inst_ready=0.
- PC update: on issue, pc <= pc + PC_STEP (ADDR_W wrap-around, no saturation).
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN on halt.
  - DRAIN -> IDLE when inflight=0 and FIFO empty.
  - start in RUN is ignored.
  - halt in IDLE is ignored.
- Redirect (any state except IDLE):
  - FIFO flushed; an in-flight response is discarded when it returns.
  - pc <= redirect_pc; fault cleared.
  - No issue in the redirect cycle; first issue at redirect_pc in the next cycle.
  - Redirect wins over a same-cycle pop and over halt; halt is then applied in the following cycle.
- Fault:
  - If pc >= MEM_DEPTH at issue time: no read, fault=1, issuing stops.
  - Already-buffered instructions still drain.
  - Cleared only by redirect or reset.
- Loader:
  - In IDLE with load_valid=1, same cycle: mem_enable=1, mem_read=0, mem_address=load_addr, mem_data_in=load_data.
  - load_valid outside IDLE is ignored (mem_* not driven for the write).
  - start and load_valid in the same cycle: the write is performed and the state moves to RUN.
- Idle bus: when neither issuing nor loading, mem_enable=0; mem_read, mem_address and mem_data_in hold 0.
- Reset mid-operation: immediate return to reset values; any in-flight response is ignored.

Test Plan:
- Load then fetch: in IDLE load addr 0..3 = 0xA0..0xA3, pulse start, inst_ready=1 → first inst_valid 2 cycles after start, then (pc,data) = (0,0xA0),(1,0xA1),(2,0xA2),(3,0xA3) on consecutive cycles.
- Backpressure: inst_ready=0 for 5 cycles after first valid → inst_valid=1, head (0,0xA0) held stable, at most 2 buffered plus 0 in flight, no mem reads issued. Release → 0xA1 follows with no gap.
- Redirect: while streaming at pc=2, redirect_pc=0x10 (mem[0x10]=0xBB) → no stale instructions delivered after the redirect, next delivered is (0x10,0xBB).
- Fault: redirect_pc=MEM_DEPTH-1 → (1023, mem[1023]) delivered, then fault=1, no further issues. A redirect to 0 clears fault and fetch resumes.
- Halt/drain: halt while 2 buffered → both delivered, busy falls after drain, state IDLE. A load_valid arriving during DRAIN is ignored (mem_enable stays 0).
- Async reset with a read in flight: rst_n low mid-cycle → all outputs 0 immediately. After release, pc=RESET_PC and inst_valid stays 0 until start.
